pe_result_drain: RTL and testbench

Result drain stage for one column of the systolic array. It captures each PE's accumulated `s_out` on that PE's `se` pulse and holds it in a per-lane register. A round-robin arbiter then moves the held results, one per cycle, onto a single valid/ready result stream for the host-side result buffer. It sits directly downstream of the PE column and is the only consumer of `se`, `sat` and `s_out`.

---
 rtl/pe_result_drain_if.sv | 14 +
 rtl/pe_result_drain.sv | 169 ++++++++++++++++
 tb/tb_pe_result_drain.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pe_result_drain_if.sv
// Result stream from the drain stage to the host-side result buffer.
// The master side presents a held result; the slave side accepts it with res_ready.
interface pe_result_drain_if #(
  parameter int IW = 4
);
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_data;
  logic [IW-1:0] res_idx;
  logic          res_sat;

  modport master (output res_valid, res_data, res_idx, res_sat, input res_ready);
  modport slave  (input res_valid, res_data, res_idx, res_sat, output res_ready);
endinterface

// File: rtl/pe_result_drain.sv
// Column result drain: per-lane capture registers feeding a round-robin
// arbiter that emits one held PE result per cycle on a valid/ready stream.
module pe_drain_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        se,
  input  logic        sat_in,
  input  logic [15:0] s_in,
  input  logic        gnt,
  input  logic        clr,
  output logic        pend,
  output logic        sat_o,
  output logic [15:0] data,
  output logic        ovf
);
  logic        pend_q, pend_d;
  logic        sat_q, sat_d;
  logic [15:0] data_q, data_d;
  logic        ovf_q, ovf_d;
  logic        cap;

  always_comb begin
    // A lane being granted this cycle is free to take a new value.
    cap    = se & (~pend_q | gnt);
    pend_d = pend_q;
    sat_d  = sat_q;
    data_d = data_q;
    if (cap) begin
      pend_d = 1'b1;
      sat_d  = sat_in;
      data_d = s_in;
    end else if (gnt) begin
      pend_d = 1'b0;
    end
    ovf_d = (clr ? 1'b0 : ovf_q) | (se & pend_q & ~gnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      sat_q  <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      sat_q  <= sat_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend  = pend_q;
  assign sat_o = sat_q;
  assign data  = data_q;
  assign ovf   = ovf_q;
endmodule

module pe_result_drain #(
  parameter int NPE = 4,
  parameter int IW  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NPE-1:0]      se,
  input  logic [NPE-1:0]      sat,
  input  logic [16*NPE-1:0]   s_out,
  input  logic                clr,
  pe_result_drain_if.master   res,
  output logic [NPE-1:0]      ovf,
  output logic [15:0]         res_cnt
);
  logic [NPE-1:0]       pend, lane_sat, gnt_oh;
  logic [NPE-1:0][15:0] lane_data;

  logic          res_valid_q, res_valid_d;
  logic [15:0]   res_data_q, res_data_d;
  logic [IW-1:0] res_idx_q, res_idx_d;
  logic          res_sat_q, res_sat_d;
  logic [IW-1:0] last_q, last_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          load, found, hs;
  logic [IW-1:0] gnt_idx;
  logic [15:0]   sel_data;
  logic          sel_sat;

  for (genvar i = 0; i < NPE; i++) begin : g_lane
    pe_drain_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .se     (se[i]),
      .sat_in (sat[i]),
      .s_in   (s_out[16*i +: 16]),
      .gnt    (gnt_oh[i]),
      .clr    (clr),
      .pend   (pend[i]),
      .sat_o  (lane_sat[i]),
      .data   (lane_data[i]),
      .ovf    (ovf[i])
    );
  end

  // Round-robin search starting just past the last granted lane.
  always_comb begin
    found   = 1'b0;
    gnt_idx = last_q;
    for (int k = 1; k <= NPE; k++) begin
      if (!found && pend[(int'(last_q) + k) % NPE]) begin
        found   = 1'b1;
        gnt_idx = IW'((int'(last_q) + k) % NPE);
      end
    end
    load = ~res_valid_q | res.res_ready;
    hs   = res_valid_q & res.res_ready;
    gnt_oh   = '0;
    sel_data = '0;
    sel_sat  = 1'b0;
    for (int i = 0; i < NPE; i++) begin
      gnt_oh[i] = load & found & (gnt_idx == IW'(i));
      if (gnt_idx == IW'(i)) begin
        sel_data = lane_data[i];
        sel_sat  = lane_sat[i];
      end
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    res_sat_d   = res_sat_q;
    last_d      = last_q;
    if (load) begin
      res_valid_d = found;
      if (found) begin
        res_data_d = sel_data;
        res_idx_d  = gnt_idx;
        res_sat_d  = sel_sat;
        last_d     = gnt_idx;
      end
    end
    // A handshake in the clearing cycle still counts.
    cnt_d = (clr ? 16'd0 : cnt_q) + {15'd0, hs};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_sat_q   <= 1'b0;
      last_q      <= IW'(NPE - 1);
      cnt_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      res_sat_q   <= res_sat_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign res.res_valid = res_valid_q;
  assign res.res_data  = res_data_q;
  assign res.res_idx   = res_idx_q;
  assign res.res_sat   = res_sat_q;
  assign res_cnt       = cnt_q;
endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: capture, drain order, back-pressure,
// overflow/clear, fairness and mid-run reset.
module tb_pe_result_drain;
  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic [3:0]  se, sat, ovf;
  logic [63:0] s_out;
  logic [15:0] res_cnt;
  int          checks = 0;
  int          errors = 0;

  pe_result_drain_if #(.IW(4)) rif ();

  pe_result_drain #(.NPE(4), .IW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .se      (se),
    .sat     (sat),
    .s_out   (s_out),
    .clr     (clr),
    .res     (rif.master),
    .ovf     (ovf),
    .res_cnt (res_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; se = '0; sat = '0; s_out = '0; clr = 1'b0; rif.res_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rif.res_valid !== 1'b0 || rif.res_data !== 16'h0 || rif.res_idx !== 4'h0 ||
        rif.res_sat !== 1'b0 || ovf !== 4'h0 || res_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h idx=%0d sat=%b ovf=%b cnt=%0d, want all zero",
               rif.res_valid, rif.res_data, rif.res_idx, rif.res_sat, ovf, res_cnt);
    end
  endtask

  task automatic test_single();
    se = 4'b0001; s_out = 64'h0123; rif.res_ready = 1'b1;
    tick(); se = '0;
    checks++;
    if (rif.res_valid !== 1'b0) begin
      errors++; $display("FAIL single_latency: valid=%b want 0 one cycle after se", rif.res_valid);
    end
    tick();
    checks++;
    if (rif.res_valid !== 1'b1 || rif.res_data !== 16'h0123 || rif.res_idx !== 4'd0 || rif.res_sat !== 1'b0) begin
      errors++;
      $display("FAIL single_result: valid=%b data=%h idx=%0d sat=%b want 1 0123 0 0",
               rif.res_valid, rif.res_data, rif.res_idx, rif.res_sat);
    end
    tick();
    checks++;
    if (res_cnt !== 16'd1 || rif.res_valid !== 1'b0) begin
      errors++; $display("FAIL single_cnt: cnt=%0d valid=%b want 1 0", res_cnt, rif.res_valid);
    end
  endtask

  task automatic test_burst();
    do_reset();
    se = 4'b1111; sat = 4'b0100; s_out = {16'd4, 16'd3, 16'd2, 16'd1}; rif.res_ready = 1'b1;
    tick(); se = '0; sat = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (rif.res_valid !== 1'b1 || rif.res_idx !== 4'(k) || rif.res_data !== 16'(k + 1) ||
          rif.res_sat !== (k == 2)) begin
        errors++;
        $display("FAIL burst_%0d: valid=%b idx=%0d data=%0d sat=%b want 1 %0d %0d %b",
                 k, rif.res_valid, rif.res_idx, rif.res_data, rif.res_sat, k, k + 1, k == 2);
      end
    end
    tick();
    checks++;
    if (rif.res_valid !== 1'b0 || res_cnt !== 16'd4 || ovf !== 4'h0) begin
      errors++;
      $display("FAIL burst_end: valid=%b cnt=%0d ovf=%b want 0 4 0000", rif.res_valid, res_cnt, ovf);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    se = 4'b0101; s_out = 64'h0000_00CC_0000_00AA;
    tick(); se = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rif.res_valid !== 1'b1 || rif.res_data !== 16'h00AA || rif.res_idx !== 4'd0) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b data=%h idx=%0d want 1 00aa 0",
                 k, rif.res_valid, rif.res_data, rif.res_idx);
      end
      tick();
    end
    rif.res_ready = 1'b1;
    tick();
    checks++;
    if (rif.res_valid !== 1'b1 || rif.res_data !== 16'h00CC || rif.res_idx !== 4'd2) begin
      errors++;
      $display("FAIL bp_second: valid=%b data=%h idx=%0d want 1 00cc 2", rif.res_valid, rif.res_data, rif.res_idx);
    end
    tick();
    checks++;
    if (rif.res_valid !== 1'b0 || res_cnt !== 16'd2) begin
      errors++; $display("FAIL bp_end: valid=%b cnt=%0d want 0 2", rif.res_valid, res_cnt);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    se = 4'b0001; s_out = 64'h0005;
    tick();
    se = 4'b0010; s_out = 64'h0000_0000_0007_0000;
    tick();
    s_out = 64'h0000_0000_0009_0000;
    tick(); se = '0;
    checks++;
    if (ovf !== 4'b0010 || rif.res_data !== 16'h0005 || rif.res_idx !== 4'd0) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b data=%h idx=%0d want 0010 0005 0", ovf, rif.res_data, rif.res_idx);
    end
    rif.res_ready = 1'b1;
    tick();
    checks++;
    if (rif.res_data !== 16'h0007 || rif.res_idx !== 4'd1 || res_cnt !== 16'd1 || ovf !== 4'b0010) begin
      errors++;
      $display("FAIL ovf_drain: data=%h idx=%0d cnt=%0d ovf=%b want 0007 1 1 0010",
               rif.res_data, rif.res_idx, res_cnt, ovf);
    end
    clr = 1'b1;
    tick();
    checks++;
    if (res_cnt !== 16'd1 || ovf !== 4'h0 || rif.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_hs: cnt=%0d ovf=%b valid=%b want 1 0000 0", res_cnt, ovf, rif.res_valid);
    end
    rif.res_ready = 1'b0;
    tick(); clr = 1'b0;
    checks++;
    if (res_cnt !== 16'd0 || ovf !== 4'h0) begin
      errors++; $display("FAIL clr_only: cnt=%0d ovf=%b want 0 0000", res_cnt, ovf);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    rif.res_ready = 1'b1;
    se = 4'b1000; s_out = 64'h0033_0000_0000_0000;
    tick();
    se = 4'b0001; s_out = 64'h0010;
    tick();
    checks++;
    if (rif.res_valid !== 1'b1 || rif.res_idx !== 4'd3 || rif.res_data !== 16'h0033) begin
      errors++;
      $display("FAIL fair_lane3: valid=%b idx=%0d data=%h want 1 3 0033", rif.res_valid, rif.res_idx, rif.res_data);
    end
    for (int k = 0; k < 4; k++) begin
      s_out = 64'(16'h0011 + 16'(k));
      tick();
      checks++;
      if (rif.res_valid !== 1'b1 || rif.res_idx !== 4'd0 || rif.res_data !== 16'(16'h0010 + 16'(k))) begin
        errors++;
        $display("FAIL fair_lane0_%0d: valid=%b idx=%0d data=%h want 1 0 %h",
                 k, rif.res_valid, rif.res_idx, rif.res_data, 16'h0010 + 16'(k));
      end
    end
    se = '0;
    tick();
    checks++;
    if (ovf !== 4'h0 || rif.res_data !== 16'h0014 || rif.res_idx !== 4'd0) begin
      errors++;
      $display("FAIL fair_tail: ovf=%b data=%h idx=%0d want 0000 0014 0", ovf, rif.res_data, rif.res_idx);
    end
    tick();
    checks++;
    if (rif.res_valid !== 1'b0 || res_cnt !== 16'd6) begin
      errors++; $display("FAIL fair_end: valid=%b cnt=%0d want 0 6", rif.res_valid, res_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    se = 4'b1111; s_out = {16'd40, 16'd30, 16'd20, 16'd10};
    tick(); se = '0;
    tick();
    rif.res_ready = 1'b1; se = 4'b0001; s_out = 64'd50;
    tick();
    rif.res_ready = 1'b0; se = '0;
    checks++;
    if (res_cnt !== 16'd1 || rif.res_valid !== 1'b1 || rif.res_idx !== 4'd1) begin
      errors++;
      $display("FAIL mid_setup: cnt=%0d valid=%b idx=%0d want 1 1 1", res_cnt, rif.res_valid, rif.res_idx);
    end
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    checks++;
    if (rif.res_valid !== 1'b0 || res_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_reset: valid=%b cnt=%0d want 0 0", rif.res_valid, res_cnt);
    end
    rif.res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (rif.res_valid !== 1'b0 || res_cnt !== 16'd0) begin
        errors++;
        $display("FAIL mid_no_emit_%0d: valid=%b cnt=%0d want 0 0", k, rif.res_valid, res_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_overflow();
    test_fairness();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
